window_conv_mac: RTL
====================

// Module: window_conv_mac
// PURPOSE
//  Consumer end of the 2-D line-buffer interface: takes one flattened FilterSize x FilterSize
//  pixel window plus its coefficient set, computes the 2-D convolution sum with a single
//  sequential multiplier, then rounds, shifts, saturates and returns one DataBitWidth pixel.
//  Sits between the 2-D window buffer and the output pixel stream. Uses valid/ready on both sides.
// PARAMETERS
//  DataBitWidth  12  signed pixel width, in and out
//  SHIFT          6  arithmetic right shift applied to the sum (coefficient fractional bits); 0 allowed
// PORTS
//  clk        in   1                 single clock, rising edge
//  rst        in   1                 asynchronous, active-low reset
//  en         in   1                 global clock enable; when low all state freezes
//  win_valid  in   1                 window/coeff inputs are valid
//  win_ready  out  1                 block can accept a window
//  win_data   in   DW*FS*FS          signed pixels; tap t=i*FS+j at bits [t*DW +: DW]
//  f_coeff    in   FS*FS*FBW         signed coeffs; tap t at bits [t*FBW +: FBW]
//  out_valid  out  1                 d_out holds a result
//  out_ready  in   1                 downstream accepts d_out
//  d_out      out  DW                signed, saturated result
//  (DW=DataBitWidth, FS=`FilterSize=5, FBW=`FilterBitWidth=8)
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, tap counter=0, accumulator=0, d_out=0, out_valid=0, win_ready=1.
//  - en=0: every register holds (state, counter, accumulator, d_out, out_valid).
//    win_ready and out_valid stay at their registered/decoded values. No handshake completes.
//  - FSM:
//    - IDLE: win_ready=1. On en&win_valid: capture win_data and f_coeff into local regs, clear acc, tap=0 -> MAC.
//    - MAC: each enabled cycle acc += data[tap]*coeff[tap] (signed DW x signed FBW); tap++.
//      After tap FS*FS-1 -> DONE. Takes exactly 25 enabled cycles.
//    - DONE: register d_out = sat(round(acc)), out_valid=1 -> HOLD.
//    - HOLD: out_valid=1 and d_out stable. On en&out_ready: out_valid=0 -> IDLE.
//  - Latency: accept edge E0; taps at E1..E25; out_valid rises after E26 (26 enabled cycles).
//    Throughput is 1 window per >=28 cycles.
//  - win_ready = (state==IDLE). Inputs are ignored outside IDLE. Captured copies decouple the block
//    from upstream changes after E0.
//  - Arithmetic: product DW+FBW bits. acc width ACCW = DW+FBW+5 (ceil log2 25). No overflow possible.
//  - Round: if SHIFT>0, acc + 2^(SHIFT-1), then arithmetic >>> SHIFT (round half up). SHIFT=0: no rounding.
//  - Saturate to [-2^(DW-1), 2^(DW-1)-1].
//  - Reset mid-MAC or mid-HOLD: the partial result is discarded and all outputs return to reset values
//    immediately (async).
// STRUCTURE
//  - Shared include/package: `FilterSize, `FilterBitWidth, ACCW derivation, FSM state encodings
//    (IDLE/MAC/DONE/HOLD), tap-index width.
//  - One natural sub-module: conv_sat_round (combinational round+shift+saturate, parameterised
//    ACCW/DW/SHIFT); instantiate once before the d_out register.
//  - Tap select is a 25:1 mux indexed by the counter; no per-tap multipliers.
// TESTING (DW=12, SHIFT=6 unless noted)
//  1. Impulse: coeff tap12=64, others 0; pixel tap12=-100 -> d_out=-100, out_valid 26 cycles after accept.
//  2. Box: SHIFT=0, all coeffs 1, all pixels 10 -> d_out=250; pixels -3 -> d_out=-75.
//  3. Saturation: all pixels 2047, coeffs 127 -> d_out=2047.
//     Pixels -2048, coeffs 127 -> d_out=-2048.
//  4. Backpressure + stall: hold out_ready=0 for 10 cycles -> d_out/out_valid stable, win_ready=0.
//     Toggle en=0 for 5 cycles mid-MAC -> result unchanged, latency +5.
//  5. Reset mid-op: rst=0 at tap 13 -> out_valid=0, d_out=0, win_ready=1 at once.
//     Next window gives the correct sum.
//  6. Back-to-back: win_valid held high with 3 different windows, out_ready=1
//     -> 3 correct results in order, one accept per IDLE visit.

Source files
------------

// File: rtl/window_conv_mac_pkg.sv
// Shared constants for the window convolution MAC: filter geometry, accumulator sizing, FSM codes.
// Latency: none (declarations only).
// Backpressure: not applicable.
`ifndef FilterSize
`define FilterSize 5
`endif
`ifndef FilterBitWidth
`define FilterBitWidth 8
`endif

package window_conv_mac_pkg;

    localparam int FILTER_SIZE      = `FilterSize;
    localparam int FILTER_BIT_WIDTH = `FilterBitWidth;
    localparam int NUM_TAPS         = FILTER_SIZE * FILTER_SIZE;

    // Tap counter width; the counter only ever walks 0..NUM_TAPS-1.
    localparam int TAP_W = $clog2(NUM_TAPS);

    // Summing NUM_TAPS products grows the magnitude by at most ceil(log2(NUM_TAPS)) bits.
    localparam int SUM_GROWTH = $clog2(NUM_TAPS);

    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);

    // Accumulator width for a given pixel width: full product plus sum growth, so it cannot overflow.
    function automatic int acc_width(input int dw);
        return dw + FILTER_BIT_WIDTH + SUM_GROWTH;
    endfunction

    // FSM encodings, kept as plain constants for older tool flows.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

endpackage

// File: rtl/window_conv_mac_conv_sat_round.sv
// Rounds (half up), arithmetically shifts and saturates an accumulator down to an output pixel.
// Latency: purely combinational.
// Backpressure: none; the caller registers the result.
module conv_sat_round #(
    parameter int ACCW  = 25,
    parameter int DW    = 12,
    parameter int SHIFT = 6
) (
    input  logic signed [ACCW-1:0] acc,
    output logic signed [DW-1:0]   d_sat
);

    // One guard bit so the rounding constant can never wrap the sum.
    localparam int RW = ACCW + 1;

    localparam logic signed [RW-1:0] MAX_V = RW'((longint'(1) <<< (DW - 1)) - 1);
    localparam logic signed [RW-1:0] MIN_V = RW'(-(longint'(1) <<< (DW - 1)));

    logic signed [RW-1:0] ext;
    logic signed [RW-1:0] rounded;
    logic signed [RW-1:0] shifted;

    assign ext = RW'(acc);

    // A zero shift has no fractional bits, so there is nothing to round.
    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [RW-1:0] HALF = RW'(longint'(1) <<< (SHIFT - 1));
            assign rounded = ext + HALF;
        end else begin : g_no_round
            assign rounded = ext;
        end
    endgenerate

    assign shifted = rounded >>> SHIFT;

    // Clamp into the signed output range.
    always_comb begin
        d_sat = shifted[DW-1:0];
        if (shifted > MAX_V) begin
            d_sat = MAX_V[DW-1:0];
        end else if (shifted < MIN_V) begin
            d_sat = MIN_V[DW-1:0];
        end
    end

endmodule

// File: rtl/window_conv_mac.sv
// Convolves one FS x FS pixel window with its coefficients using one shared multiplier, then rounds/saturates.
// Latency: accept edge, 25 MAC edges, 1 result edge -> out_valid after 26 enabled cycles.
// Backpressure: win_ready only in IDLE; result is held with out_valid until out_ready; en=0 freezes everything.
module window_conv_mac
    import window_conv_mac_pkg::*;
#(
    parameter int DataBitWidth = 12,
    parameter int SHIFT        = 6
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   en,
    input  logic                                   win_valid,
    output logic                                   win_ready,
    input  logic [DataBitWidth*NUM_TAPS-1:0]       win_data,
    input  logic [NUM_TAPS*FILTER_BIT_WIDTH-1:0]   f_coeff,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [DataBitWidth-1:0]                d_out
);

    localparam int DW   = DataBitWidth;
    localparam int FBW  = FILTER_BIT_WIDTH;
    localparam int PW   = DW + FBW;
    localparam int ACCW = acc_width(DW);

    logic [1:0]              state;
    logic [TAP_W-1:0]        tap;
    logic signed [ACCW-1:0]  acc;

    // Local copies so upstream may change win_data/f_coeff as soon as the window is accepted.
    logic signed [DW-1:0]    pix_q  [NUM_TAPS];
    logic signed [FBW-1:0]   coef_q [NUM_TAPS];

    logic signed [DW-1:0]    pix_sel;
    logic signed [FBW-1:0]   coef_sel;
    logic signed [PW-1:0]    prod;
    logic signed [DW-1:0]    sat_res;
    logic                    accept;

    assign win_ready = (state == ST_IDLE);
    assign accept    = en && win_ready && win_valid;

    // One tap per cycle through a single multiplier, selected by the tap counter.
    assign pix_sel  = pix_q[tap];
    assign coef_sel = coef_q[tap];
    assign prod     = PW'(pix_sel) * PW'(coef_sel);

    conv_sat_round #(
        .ACCW  (ACCW),
        .DW    (DW),
        .SHIFT (SHIFT)
    ) u_sat_round (
        .acc   (acc),
        .d_sat (sat_res)
    );

    // Capture the window and coefficients on the accept edge only; contents are don't-care until then.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int t = 0; t < NUM_TAPS; t++) begin
                pix_q[t]  <= win_data[t*DW +: DW];
                coef_q[t] <= f_coeff[t*FBW +: FBW];
            end
        end
    end

    // Control FSM, tap counter, accumulator and output register; all frozen while en is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            tap       <= '0;
            acc       <= '0;
            d_out     <= '0;
            out_valid <= 1'b0;
        end else if (en) begin
            case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        acc   <= '0;
                        tap   <= '0;
                        state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc <= acc + ACCW'(prod);
                    if (tap == LAST_TAP) begin
                        tap   <= '0;
                        state <= ST_DONE;
                    end else begin
                        tap <= tap + TAP_W'(1);
                    end
                end
                ST_DONE: begin
                    d_out     <= sat_res;
                    out_valid <= 1'b1;
                    state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
